// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage core: forwarding selects, result-source codes
// and the data-memory wait FSM states.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_fsm_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-status / hazard-control bundle between the datapath (master) and
// the hazard controller (slave).
interface hazard_controller_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic [REG_AW-1:0] rs1E;
  logic [REG_AW-1:0] rs2E;
  logic [REG_AW-1:0] rdE;
  logic [1:0]        resultSrcE;
  logic              PCSrcE;
  logic [REG_AW-1:0] rdM;
  logic              regWriteM;
  logic              memReqM;
  logic [REG_AW-1:0] rdW;
  logic              regWriteW;

  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushW;
  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;
  logic              memBusy;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, resultSrcE, PCSrcE,
           rdM, regWriteM, memReqM, rdW, regWriteW,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memBusy
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, resultSrcE, PCSrcE,
           rdM, regWriteM, memReqM, rdW, regWriteW,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memBusy
  );
endinterface

// File: rtl/forwarding_unit.sv
// E-stage operand forwarding select; M-stage result takes priority over W,
// and x0 is never forwarded.
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regWriteM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteW,
  output fwd_sel_t          forwardAE,
  output fwd_sel_t          forwardBE
);

  function automatic fwd_sel_t fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              we_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs)) return FWD_M;
    if (we_w && (rd_w != '0) && (rd_w == rs)) return FWD_W;
    return FWD_NONE;
  endfunction

  always_comb begin
    forwardAE = fwd_sel(rs1E, rdM, regWriteM, rdW, regWriteW);
    forwardBE = fwd_sel(rs2E, rdM, regWriteM, rdW, regWriteW);
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard control: load-use and branch flushes, E-stage forwarding,
// and a whole-pipeline hold while a multi-cycle data-memory access sits in M.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_controller_if.slave hz
);

  localparam logic             MEM_EN    = (MEM_WAIT > 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  mem_fsm_t         state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mem_stall;
  logic             lw_stall;
  fwd_sel_t         fwd_a, fwd_b;

  forwarding_unit #(
    .REG_AW(REG_AW)
  ) u_fwd (
    .rs1E      (hz.rs1E),
    .rs2E      (hz.rs2E),
    .rdM       (hz.rdM),
    .regWriteM (hz.regWriteM),
    .rdW       (hz.rdW),
    .regWriteW (hz.regWriteW),
    .forwardAE (fwd_a),
    .forwardBE (fwd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // DONE is the access's final cycle in M: no stall, and memReqM there belongs
  // to the leaving instruction, so it must not retrigger the wait.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (hz.memReqM && MEM_EN) begin
          if (MEM_WAIT == 1) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = ((state == IDLE) && hz.memReqM && MEM_EN) || (state == WAIT);
    lw_stall  = (hz.resultSrcE == RESULT_SRC_MEM) && (hz.rdE != '0) &&
                ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
  end

  // A memory hold freezes E, so branch/load-use actions are deferred, not lost.
  assign hz.stallF    = mem_stall | (lw_stall & ~hz.PCSrcE);
  assign hz.stallD    = mem_stall | (lw_stall & ~hz.PCSrcE);
  assign hz.stallE    = mem_stall;
  assign hz.stallM    = mem_stall;
  assign hz.flushW    = mem_stall;
  assign hz.flushD    = hz.PCSrcE & ~mem_stall;
  assign hz.flushE    = (hz.PCSrcE | lw_stall) & ~mem_stall;
  assign hz.forwardAE = fwd_a;
  assign hz.forwardBE = fwd_b;
  assign hz.memBusy   = (state != IDLE);

endmodule
